// File: rtl/regbus_pkg.sv
// Shared definitions for the host-byte-stream to register-bus bridge.
// Optional burst support is enabled with the REGBUS_AUTOINC_EN macro.
package regbus_pkg;

  localparam int CMD_W_BIT   = 7;
  localparam int CMD_INC_BIT = 6;

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_COUNT  = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RWAIT  = 3'd3,
    ST_RLATCH = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/regbus_bridge_if.sv
// Host byte stream, response stream and memmap register-bus signals.
// master = bridge side, slave = host link plus memmap side.
interface regbus_bridge_if #(
  parameter int ADDR_BITS = 4
);
  logic                 rx_valid_i;
  logic [7:0]           rx_data_i;
  logic                 rx_ready_o;
  logic                 tx_valid_o;
  logic [7:0]           tx_data_o;
  logic                 tx_ready_i;
  logic                 write_o;
  logic [ADDR_BITS-1:0] addr_o;
  logic [7:0]           data_o;
  logic [7:0]           data_i;
  logic                 busy_o;

  modport master (
    input  rx_valid_i, rx_data_i, tx_ready_i, data_i,
    output rx_ready_o, tx_valid_o, tx_data_o, write_o, addr_o, data_o, busy_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, tx_ready_i, data_i,
    input  rx_ready_o, tx_valid_o, tx_data_o, write_o, addr_o, data_o, busy_o
  );
endinterface

// File: rtl/regbus_bridge.sv
// Decodes host command bytes into memmap write strobes and register reads.
// REGBUS_AUTOINC_EN adds counted bursts with auto-incrementing address.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_CMD    | idle, waiting for a command byte
// ST_COUNT  | waiting for burst count byte (REGBUS_AUTOINC_EN only)
// ST_WDATA  | accepting write data bytes
// ST_RWAIT  | address presented, memmap read data settling
// ST_RLATCH | capture memmap read data into the response register
// ST_RESP   | response byte offered until host accepts it
module regbus_bridge
  import regbus_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  regbus_bridge_if.master  bus
);

  state_t               state;
  logic                 is_write;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           data_q;
  logic                 write_q;
  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;
  logic                 rx_fire;
  logic                 last;

`ifdef REGBUS_AUTOINC_EN
  // Transfers still to perform, including the current one; 256 needs 9 bits.
  logic [8:0] remaining;
  assign last = (remaining == 9'd1);
`else
  assign last = 1'b1;
`endif

  assign bus.rx_ready_o = !reset_i &&
                          (state == ST_CMD || state == ST_COUNT || state == ST_WDATA);
  assign rx_fire        = bus.rx_valid_i && bus.rx_ready_o;
  assign bus.busy_o     = (state != ST_CMD);
  assign bus.addr_o     = addr_q;
  assign bus.data_o     = data_q;
  assign bus.write_o    = write_q;
  assign bus.tx_valid_o = tx_valid_q;
  assign bus.tx_data_o  = tx_data_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= ST_CMD;
      is_write   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef REGBUS_AUTOINC_EN
      remaining  <= '0;
`endif
    end else begin
      write_q <= 1'b0;
      // Burst writes advance the address once the strobe cycle has been seen.
      if (write_q && state == ST_WDATA)
        addr_q <= addr_q + ADDR_BITS'(1);

      case (state)
        ST_CMD: begin
          if (rx_fire) begin
            addr_q   <= bus.rx_data_i[ADDR_BITS-1:0];
            is_write <= bus.rx_data_i[CMD_W_BIT];
`ifdef REGBUS_AUTOINC_EN
            remaining <= 9'd1;
            if (bus.rx_data_i[CMD_INC_BIT])
              state <= ST_COUNT;
            else
`endif
            if (bus.rx_data_i[CMD_W_BIT])
              state <= ST_WDATA;
            else
              state <= ST_RWAIT;
          end
        end
`ifdef REGBUS_AUTOINC_EN
        ST_COUNT: begin
          if (rx_fire) begin
            remaining <= {1'b0, bus.rx_data_i} + 9'd1;
            state     <= is_write ? ST_WDATA : ST_RWAIT;
          end
        end
`endif
        ST_WDATA: begin
          if (rx_fire) begin
            data_q  <= bus.rx_data_i;
            write_q <= 1'b1;
`ifdef REGBUS_AUTOINC_EN
            remaining <= remaining - 9'd1;
`endif
            if (last)
              state <= ST_CMD;
          end
        end
        ST_RWAIT:
          state <= ST_RLATCH;
        ST_RLATCH: begin
          tx_data_q  <= bus.data_i;
          tx_valid_q <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.tx_ready_i) begin
            tx_valid_q <= 1'b0;
`ifdef REGBUS_AUTOINC_EN
            remaining <= remaining - 9'd1;
`endif
            if (last) begin
              state <= ST_CMD;
            end else begin
              addr_q <= addr_q + ADDR_BITS'(1);
              state  <= ST_RWAIT;
            end
          end
        end
        default:
          state <= ST_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_bridge.sv
// Scoreboard bench for regbus_bridge with a registered-read memmap model.
// Burst tests run only when REGBUS_AUTOINC_EN is defined.
module tb_regbus_bridge;

`ifdef REGBUS_AUTOINC_EN
  localparam int AB = 2;
`else
  localparam int AB = 4;
`endif

  typedef struct {
    logic [AB-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;

  wr_t         wr_q[$];
  logic [7:0]  rd_q[$];
  int          wr_cyc[$];

  logic [7:0]  mem [2**AB];
  logic [7:0]  rd_data;

  regbus_bridge_if #(.ADDR_BITS(AB)) bus ();

  regbus_bridge #(.ADDR_BITS(AB)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memmap model: read data follows the address by one cycle
  always @(posedge clk) begin
    if (bus.write_o)
      mem[bus.addr_o] <= bus.data_o;
    rd_data <= mem[bus.addr_o];
  end
  assign bus.data_i = rd_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (bus.write_o) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.addr_o), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("write_addr", 32'(bus.addr_o), 32'(e.a));
        chk("write_data", 32'(bus.data_o), 32'(e.d));
        wr_cyc.push_back(cyc);
      end
    end
    if (bus.tx_valid_o && bus.tx_ready_i) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_resp", 32'(bus.tx_data_o), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] d;
        d = rd_q.pop_front();
        chk("resp_data", 32'(bus.tx_data_o), 32'(d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = b;
    while (!bus.rx_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_for_byte", 32'(bus.rx_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.rx_valid_i = 1'b0;
  endtask

  task automatic push_wr(input logic [AB-1:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    wr_q.push_back(e);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (rd_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_pending", 32'(rd_q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int i = 0; i < 2**AB; i++) mem[i] = 8'h00;
    rst            = 1'b1;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.tx_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready_o), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 0);
    chk("rst_tx_data",  32'(bus.tx_data_o), 0);
    chk("rst_write",    32'(bus.write_o), 0);
    chk("rst_addr",     32'(bus.addr_o), 0);
    chk("rst_data",     32'(bus.data_o), 0);
    chk("rst_busy",     32'(bus.busy_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", 32'(bus.rx_ready_o), 1);

    // single write 0x81, 0xD5
    push_wr(AB'(1), 8'hD5);
    send_byte(8'h81);
    chk("wcmd_busy", 32'(bus.busy_o), 1);
    send_byte(8'hD5);
    chk("strobe_high", 32'(bus.write_o), 1);
    chk("strobe_addr", 32'(bus.addr_o), 1);
    chk("strobe_data", 32'(bus.data_o), 32'hD5);
    chk("busy_after_write", 32'(bus.busy_o), 0);
    @(negedge clk);
    chk("strobe_one_cycle", 32'(bus.write_o), 0);

    // read with host back-pressure
    rd_q.push_back(8'hD5);
    send_byte(8'h01);
    chk("rd_t1_addr", 32'(bus.addr_o), 1);
    chk("rd_t1_tx_valid", 32'(bus.tx_valid_o), 0);
    chk("rd_t1_rx_ready", 32'(bus.rx_ready_o), 0);
    @(negedge clk);
    chk("rd_t2_tx_valid", 32'(bus.tx_valid_o), 0);
    chk("rd_t2_rx_ready", 32'(bus.rx_ready_o), 0);
    @(negedge clk);
    chk("rd_t3_tx_valid", 32'(bus.tx_valid_o), 1);
    chk("rd_t3_tx_data", 32'(bus.tx_data_o), 32'hD5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_tx_valid", 32'(bus.tx_valid_o), 1);
      chk("hold_tx_data", 32'(bus.tx_data_o), 32'hD5);
      chk("hold_rx_ready", 32'(bus.rx_ready_o), 0);
    end
    bus.tx_ready_i = 1'b1;
    @(negedge clk);
    chk("released_tx_valid", 32'(bus.tx_valid_o), 0);
    chk("released_busy", 32'(bus.busy_o), 0);
    chk("released_rx_ready", 32'(bus.rx_ready_o), 1);

`ifndef REGBUS_AUTOINC_EN
    // INC bit ignored: single write, next byte is a command
    push_wr(AB'(1), 8'h7E);
    send_byte(8'hC1);
    send_byte(8'h7E);
    chk("noinc_busy", 32'(bus.busy_o), 0);
    rd_q.push_back(8'h7E);
    send_byte(8'h01);
    wait_resp();
    chk("noinc_idle", 32'(bus.busy_o), 0);
`endif

    // reset between command and data byte
    send_byte(8'h82);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rx_ready", 32'(bus.rx_ready_o), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy_o), 0);
    chk("midrst_write", 32'(bus.write_o), 0);
    chk("midrst_addr", 32'(bus.addr_o), 0);
`ifdef REGBUS_AUTOINC_EN
    rd_q.push_back(8'hD5);
`else
    rd_q.push_back(8'h7E);
`endif
    send_byte(8'h01);
    wait_resp();

`ifdef REGBUS_AUTOINC_EN
    // 3-write burst starting at the top address, wrapping to 0
    wr_cyc.delete();
    push_wr(AB'(3), 8'h10);
    push_wr(AB'(0), 8'h11);
    push_wr(AB'(1), 8'h12);
    send_byte(8'hC3);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h11);
    send_byte(8'h12);
    chk("burst_busy_done", 32'(bus.busy_o), 0);
    @(negedge clk);
    @(negedge clk);
    chk("burst_write_count", 32'(wr_cyc.size()), 3);
    if (wr_cyc.size() == 3) begin
      chk("burst_gap_1", 32'(wr_cyc[1] - wr_cyc[0]), 1);
      chk("burst_gap_2", 32'(wr_cyc[2] - wr_cyc[1]), 1);
    end

    // INC read with count 0 gives exactly one response
    rd_q.push_back(8'h11);
    send_byte(8'h40);
    send_byte(8'h00);
    wait_resp();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cnt0_idle_busy", 32'(bus.busy_o), 0);
      chk("cnt0_no_extra_resp", 32'(bus.tx_valid_o), 0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("writes_outstanding", 32'(wr_q.size()), 0);
    chk("resps_outstanding", 32'(rd_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
